// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if
//   Pin-level external CPU bus: chip select, write and read strobes (all
//   active low and asynchronous to the fabric clock), a 16-bit word address,
//   and split data-in / data-out lines with a pad output enable.
//   master: the CPU side, which drives the address, write data and strobes.
//   slave : the responder, which drives the read data and the output enable.
interface cpu_bus_responder_if;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_oe;
   logic        cs_n;
   logic        we_n;
   logic        rd_n;

   modport master (
      output addr, data_in, cs_n, we_n, rd_n,
      input  data_out, data_oe
   );

   modport slave (
      input  addr, data_in, cs_n, we_n, rd_n,
      output data_out, data_oe
   );
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Responder for the external CPU bus. The strobes are synchronised into clk
//   and a small FSM turns each write strobe into exactly one register write.
//   Writes land in CTRL, STEP, or shadow CYCLE/DUTY/PHASE tables. The shadow
//   tables are copied to the live tables as a single atomic step when a commit
//   has been requested and the commit boundary pulse arrives. All registers
//   can be read back.
// Ports
//   clk, reset     system clock and synchronous active-high reset
//   bus            CPU bus pins (slave modport)
//   commit_strobe  one-cycle pulse marking the update boundary
//   cycle/duty/phase  live per-transducer tables
//   step           silent step size, updated directly on write
//   force_fan      CTRL bit 0
//   gpio_out       CTRL bits 7:4
module cpu_bus_responder #(
   parameter int WIDTH         = 13,
   parameter int TRANS_NUM     = 249,
   parameter int DEFAULT_CYCLE = 5000,
   parameter int DEFAULT_STEP  = 100
) (
   input  logic                                clk,
   input  logic                                reset,
   cpu_bus_responder_if.slave                  bus,
   input  logic                                commit_strobe,
   output logic [TRANS_NUM-1:0][WIDTH-1:0]     cycle,
   output logic [TRANS_NUM-1:0][WIDTH-1:0]     duty,
   output logic [TRANS_NUM-1:0][WIDTH-1:0]     phase,
   output logic [WIDTH-1:0]                    step,
   output logic                                force_fan,
   output logic [3:0]                          gpio_out
);

   localparam int IDX_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;

   typedef enum logic [1:0] {IDLE, WR, RD} state_t;

   state_t            state, state_next;
   logic [2:0]        sync_1, sync_2;
   logic              cs_s, we_s, rd_s;
   logic [1:0]        sync_fill;
   logic              armed;
   logic [15:0]       addr_q, data_q;
   logic [15:0]       wr_addr, wr_data, rd_addr;
   logic [15:0]       rd_val, data_out_q;
   logic              pending;
   logic              wr_go, wr_in_range, rd_in_range, commit_req, do_copy;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [WIDTH-1:0]  wr_val;
   logic              unused_data;

   logic [WIDTH-1:0]  cycle_sh [TRANS_NUM];
   logic [WIDTH-1:0]  duty_sh  [TRANS_NUM];
   logic [WIDTH-1:0]  phase_sh [TRANS_NUM];

   assign {cs_s, we_s, rd_s} = sync_2;

   // Two-flop synchronisers for the strobes, reset to the idle (high) level.
   // sync_fill marks when the second stage holds a real pin sample; a transfer
   // is only accepted once the strobes have been seen idle after that, so a
   // strobe that was already low across reset never starts a transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1    <= '1;
         sync_2    <= '1;
         sync_fill <= '0;
         armed     <= 1'b0;
      end else begin
         sync_1    <= {bus.cs_n, bus.we_n, bus.rd_n};
         sync_2    <= sync_1;
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && (cs_s || (we_s && rd_s)))
            armed <= 1'b1;
      end
   end

   // Address and data pins are registered every clock; the FSM decides when
   // the registered copies are actually used.
   always_ff @(posedge clk) begin
      addr_q <= bus.addr;
      data_q <= bus.data_in;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic. A write wins when both strobes are seen low together.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (armed && !cs_s && !we_s)
               state_next = WR;
            else if (armed && !cs_s && !rd_s)
               state_next = RD;
         end
         WR: if (we_s || cs_s) state_next = IDLE;
         RD: if (rd_s || cs_s) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Write address/data track the pins while the write is in progress and
   // freeze on the exit cycle. The read address is captured on entry to RD.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_addr <= '0;
         wr_data <= '0;
         rd_addr <= '0;
      end else begin
         if (state_next == WR) begin
            wr_addr <= addr_q;
            wr_data <= data_q;
         end
         if (state == IDLE && state_next == RD)
            rd_addr <= addr_q;
      end
   end

   assign wr_go       = (state == WR) && (we_s || cs_s);
   assign wr_in_range = ({1'b0, wr_addr[7:0]} < 9'(TRANS_NUM));
   assign rd_in_range = ({1'b0, rd_addr[7:0]} < 9'(TRANS_NUM));
   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];
   assign wr_val      = wr_data[WIDTH-1:0];
   assign commit_req  = wr_go && (wr_addr == 16'h0000) && wr_data[15];
   assign do_copy     = commit_strobe && pending;
   assign unused_data = ^wr_data[14:8];

   // CTRL, STEP and the commit-pending flag. A commit request arriving with
   // the boundary pulse keeps pending set, so the new request is honoured at
   // the following boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         force_fan <= 1'b0;
         gpio_out  <= '0;
         step      <= WIDTH'(DEFAULT_STEP);
         pending   <= 1'b0;
      end else begin
         if (wr_go && wr_addr == 16'h0000) begin
            force_fan <= wr_data[0];
            gpio_out  <= wr_data[7:4];
         end
         if (wr_go && wr_addr == 16'h0001)
            step <= wr_val;
         if (commit_req)
            pending <= 1'b1;
         else if (do_copy)
            pending <= 1'b0;
      end
   end

   // Shadow and live tables. The copy reads the shadows before this edge's
   // write takes effect, so a simultaneous shadow write misses this commit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TRANS_NUM; i++) begin
            cycle_sh[i] <= WIDTH'(DEFAULT_CYCLE);
            duty_sh[i]  <= '0;
            phase_sh[i] <= '0;
            cycle[i]    <= WIDTH'(DEFAULT_CYCLE);
            duty[i]     <= '0;
            phase[i]    <= '0;
         end
      end else begin
         if (do_copy) begin
            for (int i = 0; i < TRANS_NUM; i++) begin
               cycle[i] <= cycle_sh[i];
               duty[i]  <= duty_sh[i];
               phase[i] <= phase_sh[i];
            end
         end
         if (wr_go && wr_in_range) begin
            case (wr_addr[15:8])
               8'h01:   cycle_sh[wr_idx] <= wr_val;
               8'h02:   duty_sh[wr_idx]  <= wr_val;
               8'h03:   phase_sh[wr_idx] <= wr_val;
               default: ;
            endcase
         end
      end
   end

   // Read-back multiplexer; anything unmapped reads as zero.
   always_comb begin
      rd_val = '0;
      case (rd_addr[15:8])
         8'h00: begin
            case (rd_addr[7:0])
               8'h00:   rd_val = {8'h00, gpio_out, 3'b000, force_fan};
               8'h01:   rd_val = 16'(step);
               8'h02:   rd_val = {15'h0000, pending};
               default: ;
            endcase
         end
         8'h01:   if (rd_in_range) rd_val = 16'(cycle_sh[rd_idx]);
         8'h02:   if (rd_in_range) rd_val = 16'(duty_sh[rd_idx]);
         8'h03:   if (rd_in_range) rd_val = 16'(phase_sh[rd_idx]);
         default: ;
      endcase
   end

   // Registered read data, valid from the second cycle in RD onwards.
   always_ff @(posedge clk) begin
      if (reset)
         data_out_q <= '0;
      else if (state == RD)
         data_out_q <= rd_val;
      else
         data_out_q <= '0;
   end

   assign bus.data_out = data_out_q;
   assign bus.data_oe  = (state == RD);

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder
//   Directed bench for cpu_bus_responder. Reads push their expected data into
//   a queue; a monitor pops and compares once the read data is valid on the
//   bus. Table and control outputs are compared directly after each step.
module tb_cpu_bus_responder;
   localparam int WIDTH     = 13;
   localparam int TRANS_NUM = 249;

   logic clk;
   logic reset;
   logic commitStrobe;
   logic [TRANS_NUM-1:0][WIDTH-1:0] cycle, duty, phase;
   logic [WIDTH-1:0] step;
   logic forceFan;
   logic [3:0] gpioOut;

   int errors;
   int checks;
   int oeCycles;
   logic [15:0] expQ[$];

   cpu_bus_responder_if bus();

   cpu_bus_responder #(
      .WIDTH(WIDTH),
      .TRANS_NUM(TRANS_NUM),
      .DEFAULT_CYCLE(5000),
      .DEFAULT_STEP(100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .commit_strobe(commitStrobe),
      .cycle(cycle),
      .duty(duty),
      .phase(phase),
      .step(step),
      .force_fan(forceFan),
      .gpio_out(gpioOut)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Direct comparison of an observed value against a bench constant.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One full write strobe. With strobeAtWrite the commit pulse is placed on
   // the clock edge where the synchronised write completes (third rising edge
   // after the WE_N pin rises).
   task automatic cpuWrite(input logic [15:0] a, input logic [15:0] d, input bit strobeAtWrite);
      @(negedge clk);
      bus.addr    = a;
      bus.data_in = d;
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.we_n = 1'b0;
      repeat (4) @(negedge clk);
      bus.we_n = 1'b1;
      bus.cs_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      if (strobeAtWrite) commitStrobe = 1'b1;
      @(negedge clk);
      commitStrobe = 1'b0;
      @(negedge clk);
   endtask

   // One read strobe; the expected data goes to the scoreboard queue.
   task automatic cpuRead(input logic [15:0] a, input logic [15:0] expected);
      @(negedge clk);
      checkOutput("oe_before_read", 32'(bus.data_oe), 32'd0);
      bus.addr = a;
      @(negedge clk);
      expQ.push_back(expected);
      bus.cs_n = 1'b0;
      bus.rd_n = 1'b0;
      repeat (6) @(negedge clk);
      bus.rd_n = 1'b1;
      bus.cs_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("oe_after_read", 32'(bus.data_oe), 32'd0);
   endtask

   task automatic pulseCommit();
      @(negedge clk);
      commitStrobe = 1'b1;
      @(negedge clk);
      commitStrobe = 1'b0;
   endtask

   // Monitor: the second falling edge with OE high is the first one where the
   // registered read data is valid; compare it against the oldest expectation.
   initial begin
      oeCycles = 0;
      forever begin
         @(negedge clk);
         if (bus.data_oe === 1'b1) begin
            oeCycles++;
            if (oeCycles == 2) begin
               checks++;
               if (expQ.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL read_unexpected: got data %0d with no read pending", bus.data_out);
               end else begin
                  logic [15:0] exp;
                  exp = expQ.pop_front();
                  if (bus.data_out !== exp) begin
                     errors++;
                     $display("[TB] FAIL read_data: got %0d, expected %0d", bus.data_out, exp);
                  end
               end
            end
         end else begin
            oeCycles = 0;
         end
      end
   end

   // Main directed sequence.
   initial begin
      errors       = 0;
      checks       = 0;
      reset        = 1'b1;
      commitStrobe = 1'b0;
      bus.cs_n     = 1'b1;
      bus.we_n     = 1'b1;
      bus.rd_n     = 1'b1;
      bus.addr     = '0;
      bus.data_in  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_step", 32'(step), 32'd100);
      checkOutput("rst_force_fan", 32'(forceFan), 32'd0);
      checkOutput("rst_gpio", 32'(gpioOut), 32'd0);
      checkOutput("rst_oe", 32'(bus.data_oe), 32'd0);
      checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
      checkOutput("rst_cycle0", 32'(cycle[0]), 32'd5000);
      checkOutput("rst_cycle248", 32'(cycle[248]), 32'd5000);
      checkOutput("rst_duty0", 32'(duty[0]), 32'd0);

      $display("[TB] duty write and commit");
      cpuWrite(16'h0205, 16'd1234, 1'b0);
      checkOutput("duty5_before_commit", 32'(duty[5]), 32'd0);
      cpuWrite(16'h0000, 16'h8000, 1'b0);
      cpuRead(16'h0002, 16'h0001);
      pulseCommit();
      checkOutput("duty5_after_commit", 32'(duty[5]), 32'd1234);
      cpuRead(16'h0002, 16'h0000);

      $display("[TB] phase shadow write without commit");
      cpuWrite(16'h0300, 16'd2500, 1'b0);
      checkOutput("phase0_uncommitted", 32'(phase[0]), 32'd0);
      cpuRead(16'h0300, 16'd2500);
      pulseCommit();
      checkOutput("phase0_no_pending", 32'(phase[0]), 32'd0);

      $display("[TB] out of range and unmapped");
      cpuWrite(16'h01F9, 16'd999, 1'b0);
      cpuWrite(16'h0400, 16'd55, 1'b0);
      cpuWrite(16'h01F8, 16'd4321, 1'b0);
      cpuWrite(16'h0101, 16'hFFFF, 1'b0);
      cpuWrite(16'h0002, 16'h0001, 1'b0);
      cpuRead(16'h01F9, 16'h0000);
      cpuRead(16'h0400, 16'h0000);
      cpuRead(16'h01F8, 16'd4321);
      cpuRead(16'h0101, 16'h1FFF);
      cpuRead(16'h0002, 16'h0000);
      checkOutput("cycle248_shadow_only", 32'(cycle[248]), 32'd5000);

      $display("[TB] commit request coinciding with boundary");
      cpuWrite(16'h0207, 16'd333, 1'b0);
      cpuWrite(16'h0000, 16'h8000, 1'b0);
      cpuWrite(16'h0000, 16'h8000, 1'b1);
      checkOutput("duty7_copied", 32'(duty[7]), 32'd333);
      checkOutput("cycle248_copied", 32'(cycle[248]), 32'd4321);
      checkOutput("cycle1_masked", 32'(cycle[1]), 32'd8191);
      cpuRead(16'h0002, 16'h0001);
      cpuWrite(16'h0208, 16'd444, 1'b1);
      checkOutput("duty8_prewrite_copy", 32'(duty[8]), 32'd0);
      cpuRead(16'h0002, 16'h0000);
      cpuRead(16'h0208, 16'd444);
      cpuWrite(16'h0000, 16'h8000, 1'b0);
      pulseCommit();
      checkOutput("duty8_second_commit", 32'(duty[8]), 32'd444);

      $display("[TB] ctrl and step direct update");
      cpuWrite(16'h0000, 16'h00F1, 1'b0);
      checkOutput("force_fan_set", 32'(forceFan), 32'd1);
      checkOutput("gpio_set", 32'(gpioOut), 32'hF);
      cpuWrite(16'h0001, 16'h1FFF, 1'b0);
      checkOutput("step_max", 32'(step), 32'd8191);
      cpuRead(16'h0000, 16'h00F1);

      $display("[TB] reset during write");
      cpuWrite(16'h0103, 16'd777, 1'b0);
      cpuWrite(16'h0000, 16'h8000, 1'b0);
      pulseCommit();
      checkOutput("cycle3_committed", 32'(cycle[3]), 32'd777);
      @(negedge clk);
      bus.addr    = 16'h0001;
      bus.data_in = 16'h0123;
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.we_n = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      checkOutput("step_after_reset", 32'(step), 32'd100);
      checkOutput("cycle3_after_reset", 32'(cycle[3]), 32'd5000);
      checkOutput("force_fan_after_reset", 32'(forceFan), 32'd0);
      bus.we_n = 1'b1;
      bus.cs_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("step_write_discarded", 32'(step), 32'd100);
      cpuWrite(16'h0001, 16'h0055, 1'b0);
      checkOutput("step_after_new_write", 32'(step), 32'd85);
      cpuRead(16'h0103, 16'd5000);

      for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
      if (expQ.size() != 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL read_timeout: %0d reads never presented, expected 0", expQ.size());
      end

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
